load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the multicycle RISC-V controller/datapath and `data_memory`, on the upstream side of the memory. It turns RV32I load and store requests (byte, halfword and word, signed and unsigned) into word-wide accesses on the 32-bit word memory, using read-modify-write for sub-word stores. The block runs a small state machine with a start/done handshake. It returns sign- or zero-extended load data and flags misaligned or illegal accesses without touching memory.

## Interface
- ADDR_W, 32, byte-address width of `addr` and `mem_A`.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  ADDR_W  byte address.
- store_data  in  32  store source; low byte/half is used for sb/sh.
- mem_RD  in  32  word read data from `data_memory` (combinational read of `mem_A`).
- mem_A  out  ADDR_W  word-aligned address to memory, {addr[ADDR_W-1:2],2'b00}.
- mem_WD  out  32  write data to memory.
- mem_WE  out  1  memory write enable; the memory writes on the rising edge.
- load_data  out  32  extended load result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with `done`; misaligned or illegal access.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, `start`=1: latch `addr`, `funct3`, `is_store` and `store_data`, then decode the request:
  - fault → DONE with fault_q=1.
  - sw → WRITE.
  - anything else → READ.
- Fault conditions:
  - h/hu/sh with addr[0]=1.
  - w/sw with addr[1:0]≠0.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
- READ: drive `mem_A` with the aligned address and hold `mem_WE`=0. Capture `mem_RD` into word_q.
  - Load → DONE, with `load_data` registered from the extracted lane.
  - sb/sh → WRITE.
- Lane selection is little-endian:
  - Byte k = word[8k+7:8k], with k=addr[1:0].
  - Half = addr[1] ? word[31:16] : word[15:0].
- Extension:
  - b and h sign-extend from bit 7 and bit 15.
  - bu and hu zero-extend.
  - w passes the word through.
- WRITE: `mem_WE`=1 for exactly this cycle, with `mem_A` aligned.
  - sw: `mem_WD` = store_data.
  - sb: word_q with byte lane k replaced by store_data[7:0].
  - sh: word_q with the half lane replaced by store_data[15:0].
  - Next state → DONE.
- DONE: `done`=1 and `fault`=fault_q, then → IDLE.
- Outside READ/WRITE: `mem_A`=0, `mem_WD`=0, `mem_WE`=0.
- `load_data` holds its value until the next completed load. Stores and faults leave it unchanged.
- `start` while busy is ignored, with no queueing.
- `mem_WE` is asserted only in WRITE and never on a faulting request.

## Timing
- Reset (rst=0): state=IDLE immediately. `load_data`=0, `done`=0, `fault`=0, `busy`=0, `mem_WE`=0, `mem_A`=0, `mem_WD`=0. Internal latches are cleared.
- Reset mid-operation: the state machine aborts at once. `mem_WE` drops combinationally, so no partial write occurs. After release, the block waits in IDLE for a fresh `start`.
- Latency from the edge that samples `start` to the `done` cycle (E = that edge):
  - Loads: READ at E+1, DONE at E+2.
  - sw: WRITE at E+1, DONE at E+2.
  - sb/sh: READ at E+1, WRITE at E+2, DONE at E+3.
  - Fault: DONE at E+1.
- `load_data` is valid in the DONE cycle.
- The store takes effect in memory at the rising edge that ends WRITE.
- `start` is honoured in the cycle after DONE (IDLE). `start` held high during DONE is not accepted until IDLE.

## Test plan
- sw addr=8, data=0x11223344 → `mem_WE`=1 for one cycle with `mem_A`=8 and `mem_WD`=0x11223344. `done` comes 2 cycles after start. A following lw addr=8 returns 0x11223344.
- Word 8 = 0x11A23344:
  - lb addr=10 → 0xFFFFFFA2.
  - lbu addr=10 → 0x000000A2.
  - lh addr=10 → 0x000011A2.
  - lb addr=11 → 0x00000011.
- sb addr=5, data=0xDEADBEEF on zeroed word 4 → `mem_WD`=0x0000EF00, `done` 3 cycles after start. Then sh addr=6, data=0x00001234 → word 4 = 0x1234EF00. lhu addr=6 → 0x00001234.
- Each of the following → `done` and `fault`=1 one cycle after start, `mem_WE` never high, `load_data` unchanged:
  - lw addr=6.
  - sh addr=3.
  - lh addr=1.
  - Load funct3=011.
  - Store funct3=100.
- Reset mid-operation: sb addr=4 started, rst pulled low during READ → `busy`=0 and `mem_WE`=0 immediately. After release, lw addr=4 returns the pre-store value.
- A second `start` pulsed during READ of a lw is ignored: exactly one `done` pulse, and a single access at the first address.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and word-memory signals of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic [31:0]       mem_RD;
  logic [ADDR_W-1:0] mem_A;
  logic [31:0]       mem_WD;
  logic              mem_WE;
  logic [31:0]       load_data;
  logic              busy;
  logic              done;
  logic              fault;

  // LSU view: requests and read data in, memory controls and results out
  modport slave (
    input  start, is_store, funct3, addr, store_data, mem_RD,
    output mem_A, mem_WD, mem_WE, load_data, busy, done, fault
  );

  // Environment view: controller plus data memory
  modport master (
    output start, is_store, funct3, addr, store_data, mem_RD,
    input  mem_A, mem_WD, mem_WE, load_data, busy, done, fault
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-wide memory accesses, read-modify-write for sb/sh,
// sign/zero extension of loads and fault detection without touching memory.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                is_store_q, is_store_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                fault_q, fault_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fault_o_q, fault_o_d;

  // Illegal funct3 for the direction, or address not aligned to the access size
  function automatic logic is_fault(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic f;
    f = 1'b1;
    case (f3)
      3'b000:  f = 1'b0;
      3'b001:  f = a[0];
      3'b010:  f = |a;
      3'b100:  f = st;
      3'b101:  f = st | a[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Pick the addressed lane out of a word and extend it to 32 bits
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w, input logic [2:0] f3,
                                                 input logic [1:0] a);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Build the write word: full word for sw, old word with one lane replaced for sb/sh
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w, input logic [2:0] f3,
                                               input logic [1:0] a, input logic [DATA_W-1:0] sd);
    logic [DATA_W-1:0] r;
    r = w;
    case (f3)
      3'b000:  r[{a, 3'b000} +: 8]     = sd[7:0];
      3'b001:  r[{a[1], 4'b0000} +: 16] = sd[15:0];
      default: r = sd;
    endcase
    return r;
  endfunction

  // State, request latches and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      sdata_q     <= '0;
      word_q      <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_o_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      sdata_q     <= sdata_d;
      word_q      <= word_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_o_q   <= fault_o_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    sdata_d     = sdata_q;
    word_d      = word_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d     = bus.addr;
          funct3_d   = bus.funct3;
          is_store_d = bus.is_store;
          sdata_d    = bus.store_data;
          fault_d    = is_fault(bus.is_store, bus.funct3, bus.addr[1:0]);
          if (fault_d)                                   state_d = DONE;
          else if (bus.is_store && bus.funct3 == 3'b010) state_d = WRITE;
          else                                           state_d = READ;
        end
      end
      READ: begin
        word_d = bus.mem_RD;
        if (is_store_q) begin
          state_d = WRITE;
        end else begin
          load_data_d = extract(bus.mem_RD, funct3_q, addr_q[1:0]);
          state_d     = DONE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    mem_we_d  = (state_d == WRITE);
    mem_a_d   = (state_d == READ || state_d == WRITE) ? {addr_d[ADDR_W-1:2], 2'b00} : '0;
    mem_wd_d  = mem_we_d ? merge(word_d, funct3_d, addr_d[1:0], sdata_d) : '0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    fault_o_d = (state_d == DONE) && fault_d;
  end

  assign bus.mem_A     = mem_a_q;
  assign bus.mem_WD    = mem_wd_q;
  assign bus.mem_WE    = mem_we_q;
  assign bus.load_data = load_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_o_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-array model.
module tb_load_store_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory seen by the DUT: combinational read, write on the rising edge
  logic [31:0] mem [16];
  assign bus.mem_RD = mem[bus.mem_A[5:2]];
  always @(posedge clk) if (bus.mem_WE) mem[bus.mem_A[5:2]] <= bus.mem_WD;

  // Reference model: byte-addressed memory image and last load result
  logic [7:0]  ref_mem [64];
  logic [31:0] model_ld;

  function automatic logic model_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    logic legal;
    if (st) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size = 1 << f3[1:0];
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [5:0] i;
    i = {a[5:2], 2'b00};
    return {ref_mem[i + 6'd3], ref_mem[i + 6'd2], ref_mem[i + 6'd1], ref_mem[i]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [5:0]  i;
    logic [7:0]  b;
    logic [15:0] h;
    i = a[5:0];
    b = ref_mem[i];
    h = {ref_mem[i + 6'd1], ref_mem[i]};
    case (f3)
      3'd0:    return (b >= 8'd128) ? 32'hFFFFFF00 | 32'(b) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 16'd32768) ? 32'hFFFF0000 | 32'(h) : 32'(h);
      3'd5:    return 32'(h);
      default: return model_word(a);
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    logic [5:0] i;
    n = 1 << f3[1:0];
    i = a[5:0];
    for (int k = 0; k < n; k++) ref_mem[i + 6'(k)] = d[8*k +: 8];
  endtask

  function automatic int model_latency(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (model_fault(st, f3, a)) return 1;
    if (!st || f3 == 3'd2) return 2;
    return 3;
  endfunction

  // One request; reports done latency, fault, load_data at done and the memory writes seen
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic flt, output logic [31:0] ld,
                        output int wes, output logic [31:0] wa, output logic [31:0] wd);
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.store_data = d;
    lat = 0; flt = 1'b0; ld = 32'h0; wes = 0; wa = 32'h0; wd = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.addr = $urandom(); bus.store_data = $urandom(); bus.funct3 = 3'($urandom_range(0, 7));
      if (bus.mem_WE) begin wes++; wa = bus.mem_A; wd = bus.mem_WD; end
      if (bus.done) begin lat = i; flt = bus.fault; ld = bus.load_data; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'h0; bus.store_data = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    model_ld = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if ({bus.busy, bus.done, bus.fault, bus.mem_WE} !== 4'b0000) $display("FAIL reset_ctrl busy/done/fault/we=%b want 0000", {bus.busy, bus.done, bus.fault, bus.mem_WE}); else n_pass++;
    n_checks++; if (bus.load_data !== 32'h0) $display("FAIL reset_load_data got %h want 0", bus.load_data); else n_pass++;
    n_checks++; if ({bus.mem_A, bus.mem_WD} !== 64'h0) $display("FAIL reset_mem got A=%h WD=%h want 0", bus.mem_A, bus.mem_WD); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_word();
    int lat, wes; logic flt; logic [31:0] ld, wa, wd;
    run_op(1'b1, 3'd2, 32'd8, 32'h11223344, lat, flt, ld, wes, wa, wd);
    model_store(3'd2, 32'd8, 32'h11223344);
    n_checks++; if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else n_pass++;
    n_checks++; if (wes !== 1 || wa !== 32'd8 || wd !== 32'h11223344) $display("FAIL sw_write got n=%0d A=%h WD=%h want 1/8/11223344", wes, wa, wd); else n_pass++;
    run_op(1'b0, 3'd2, 32'd8, 32'h0, lat, flt, ld, wes, wa, wd);
    model_ld = 32'h11223344;
    n_checks++; if (lat !== 2 || flt !== 1'b0 || ld !== 32'h11223344) $display("FAIL lw_8 got lat=%0d f=%b ld=%h want 2/0/11223344", lat, flt, ld); else n_pass++;
  endtask

  task automatic test_load_ext();
    int lat, wes; logic flt; logic [31:0] ld, wa, wd;
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd0};
    logic [31:0] as  [4] = '{32'd10, 32'd10, 32'd10, 32'd11};
    logic [31:0] exp [4] = '{32'hFFFFFFA2, 32'h000000A2, 32'h000011A2, 32'h00000011};
    run_op(1'b1, 3'd0, 32'd10, 32'h000000A2, lat, flt, ld, wes, wa, wd);
    model_store(3'd0, 32'd10, 32'h000000A2);
    n_checks++; if (wd !== 32'h11A23344) $display("FAIL sb_10 got WD=%h want 11a23344", wd); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3s[i], as[i], 32'h0, lat, flt, ld, wes, wa, wd);
      model_ld = exp[i];
      n_checks++; if (lat !== 2 || ld !== exp[i] || wes !== 0) $display("FAIL load_ext_%0d got lat=%0d ld=%h we=%0d want 2/%h/0", i, lat, ld, wes, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_subword_store();
    int lat, wes; logic flt; logic [31:0] ld, wa, wd;
    run_op(1'b1, 3'd0, 32'd5, 32'hDEADBEEF, lat, flt, ld, wes, wa, wd);
    model_store(3'd0, 32'd5, 32'hDEADBEEF);
    n_checks++; if (lat !== 3 || wes !== 1 || wa !== 32'd4 || wd !== 32'h0000EF00) $display("FAIL sb_5 got lat=%0d n=%0d A=%h WD=%h want 3/1/4/0000ef00", lat, wes, wa, wd); else n_pass++;
    run_op(1'b1, 3'd1, 32'd6, 32'h00001234, lat, flt, ld, wes, wa, wd);
    model_store(3'd1, 32'd6, 32'h00001234);
    n_checks++; if (lat !== 3 || wd !== 32'h1234EF00) $display("FAIL sh_6 got lat=%0d WD=%h want 3/1234ef00", lat, wd); else n_pass++;
    n_checks++; if (mem[1] !== 32'h1234EF00) $display("FAIL word4 got %h want 1234ef00", mem[1]); else n_pass++;
    run_op(1'b0, 3'd5, 32'd6, 32'h0, lat, flt, ld, wes, wa, wd);
    model_ld = 32'h00001234;
    n_checks++; if (ld !== 32'h00001234) $display("FAIL lhu_6 got %h want 00001234", ld); else n_pass++;
  endtask

  task automatic test_faults();
    int lat, wes; logic flt; logic [31:0] ld, wa, wd;
    logic        sts [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'd2, 3'd1, 3'd1, 3'd3, 3'd4};
    logic [31:0] as  [5] = '{32'd6, 32'd3, 32'd1, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(sts[i], f3s[i], as[i], 32'hA5A5A5A5, lat, flt, ld, wes, wa, wd);
      n_checks++; if (lat !== 1 || flt !== 1'b1 || wes !== 0 || ld !== model_ld) $display("FAIL fault_%0d got lat=%0d f=%b we=%0d ld=%h want 1/1/0/%h", i, lat, flt, wes, ld, model_ld); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, wes; logic flt; logic [31:0] ld, wa, wd;
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'd0; bus.addr = 32'd4; bus.store_data = 32'h55;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", bus.busy); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_WE !== 1'b0 || bus.load_data !== 32'h0) $display("FAIL midrst_abort got busy=%b we=%b ld=%h want 0/0/0", bus.busy, bus.mem_WE, bus.load_data); else n_pass++;
    model_ld = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 3'd2, 32'd4, 32'h0, lat, flt, ld, wes, wa, wd);
    model_ld = model_word(32'd4);
    n_checks++; if (lat !== 2 || ld !== 32'h1234EF00) $display("FAIL midrst_lw got lat=%0d ld=%h want 2/1234ef00", lat, ld); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int dones, wrong;
    dones = 0; wrong = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'd2; bus.addr = 32'd8;
    @(negedge clk);
    bus.addr = 32'd12;
    if (bus.mem_A !== 32'd8) wrong++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dones++;
      if (bus.mem_A === 32'd12) wrong++;
    end
    model_ld = model_word(32'd8);
    n_checks++; if (dones !== 1 || wrong !== 0) $display("FAIL busy_start got dones=%0d bad_accesses=%0d want 1/0", dones, wrong); else n_pass++;
    n_checks++; if (bus.load_data !== model_ld) $display("FAIL busy_start_ld got %h want %h", bus.load_data, model_ld); else n_pass++;
  endtask

  task automatic test_random();
    int lat, wes, elat; logic flt, eflt, st; logic [2:0] f3; logic [31:0] a, d, ld, wa, wd;
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d  = $urandom();
      eflt = model_fault(st, f3, a);
      elat = model_latency(st, f3, a);
      run_op(st, f3, a, d, lat, flt, ld, wes, wa, wd);
      if (!eflt && st) model_store(f3, a, d);
      if (!eflt && !st) model_ld = model_load(f3, a);
      n_checks++; if (lat !== elat || flt !== eflt) $display("FAIL rnd_%0d_ctrl st=%b f3=%0d a=%h got lat=%0d f=%b want %0d/%b", n, st, f3, a, lat, flt, elat, eflt); else n_pass++;
      n_checks++; if (ld !== model_ld) $display("FAIL rnd_%0d_ld st=%b f3=%0d a=%h got %h want %h", n, st, f3, a, ld, model_ld); else n_pass++;
      if (!eflt && st) begin
        n_checks++; if (wes !== 1 || wa !== {a[31:2], 2'b00} || wd !== model_word(a)) $display("FAIL rnd_%0d_wr f3=%0d a=%h got n=%0d A=%h WD=%h want 1/%h/%h", n, f3, a, wes, wa, wd, {a[31:2], 2'b00}, model_word(a)); else n_pass++;
      end else begin
        n_checks++; if (wes !== 0) $display("FAIL rnd_%0d_nowr got %0d writes want 0", n, wes); else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_word();
    test_load_ext();
    test_subword_store();
    test_faults();
    test_reset_mid_op();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
